// File: rtl/handshake_arr_merge.sv
// Round-robin collector for the handshake_arr lanes: one grant per cycle into a
// small FIFO, re-emitted on a single ready/valid output tagged with its source lane.
module handshake_arr_merge #(
  parameter int N     = 3,
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N-1:0]           handshake_arr_valid,
  input  logic [N*WIDTH-1:0]     handshake_arr_data,
  output logic [N-1:0]           handshake_arr_ready,
  output logic                   handshake_valid,
  output logic [WIDTH-1:0]       handshake_data,
  output logic [1:0]             handshake_lane,
  input  logic                   handshake_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]       ptr;
  logic [1:0]       grant;
  logic [1:0]       ptr_next;
  logic [2:0]       idx;
  logic [3:0]       valid_pad;
  logic             found;
  logic             any_valid;
  logic             can_accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] grant_data;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [1:0]       lane_mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  // First valid lane found searching from ptr upward, wrapping modulo N.
  always_comb begin
    valid_pad = 4'(handshake_arr_valid);
    grant     = ptr;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(N)) idx = idx - 3'(N);
      if (!found && valid_pad[idx[1:0]]) begin
        found = 1'b1;
        grant = idx[1:0];
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == 2'(i)) grant_data = handshake_arr_data[i*WIDTH +: WIDTH];
    end
  end

  assign any_valid  = |handshake_arr_valid;
  assign can_accept = any_valid && (count < CW'(DEPTH)) && !RESET;
  assign push       = can_accept;
  assign pop        = handshake_valid && handshake_ready;
  assign ptr_next   = (grant == 2'(N-1)) ? 2'd0 : grant + 2'd1;

  always_comb begin
    handshake_arr_ready = '0;
    for (int i = 0; i < N; i++) begin
      handshake_arr_ready[i] = can_accept && (grant == 2'(i));
    end
  end

  assign handshake_valid = (count != '0);
  assign handshake_data  = data_mem[head];
  assign handshake_lane  = lane_mem[head];

  // Lane tags are cleared on reset so the head lane reads 0; payloads are kept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) lane_mem[i] <= '0;
    end else begin
      if (push) begin
        data_mem[tail] <= grant_data;
        lane_mem[tail] <= grant;
        tail           <= tail + 1'b1;
        ptr            <= ptr_next;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_arr_merge.sv
// Bench for handshake_arr_merge: directed vector table, hand-written backpressure
// and reset sequences, then random traffic against a queue-based reference model.
module tb_handshake_arr_merge;

  localparam int N     = 3;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             CLK;
  logic             RESET;
  logic [N-1:0]     handshake_arr_valid;
  logic [N*WIDTH-1:0] handshake_arr_data;
  logic [N-1:0]     handshake_arr_ready;
  logic             handshake_valid;
  logic [WIDTH-1:0] handshake_data;
  logic [1:0]       handshake_lane;
  logic             handshake_ready;
  logic [1:0]       count;

  handshake_arr_merge #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .handshake_arr_valid (handshake_arr_valid),
    .handshake_arr_data  (handshake_arr_data),
    .handshake_arr_ready (handshake_arr_ready),
    .handshake_valid     (handshake_valid),
    .handshake_data      (handshake_data),
    .handshake_lane      (handshake_lane),
    .handshake_ready     (handshake_ready),
    .count               (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [11:0] data;
    logic        hready;
    logic [2:0]  exp_ready;
    logic [1:0]  exp_count;
    logic        exp_hvalid;
    logic        chk_valid;
    logic [1:0]  exp_lane;
    logic [3:0]  exp_data;
  } vec_t;

  typedef struct {
    int         lane;
    logic [3:0] data;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  tbl [13];

  function automatic vec_t mk(logic rst, logic [2:0] v, logic [11:0] d, logic hr,
                              logic [2:0] er, logic [1:0] ec, logic ev, logic cv,
                              logic [1:0] el, logic [3:0] ed);
    vec_t r;
    r = '{rst, v, d, hr, er, ec, ev, cv, el, ed};
    return r;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic rst, input logic [2:0] v,
                               input logic [11:0] d, input logic hr);
    @(negedge CLK);
    RESET               = rst;
    handshake_arr_valid = v;
    handshake_arr_data  = d;
    handshake_ready     = hr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] er, input logic [1:0] ec,
                             input logic ev, input logic cv, input logic [1:0] el,
                             input logic [3:0] ed);
    checkVal({name, ".ready"}, int'(handshake_arr_ready), int'(er));
    checkVal({name, ".count"}, int'(count), int'(ec));
    if (cv) begin
      checkVal({name, ".valid"}, int'(handshake_valid), int'(ev));
      if (ev) begin
        checkVal({name, ".lane"}, int'(handshake_lane), int'(el));
        checkVal({name, ".data"}, int'(handshake_data), int'(ed));
      end
    end
  endtask

  beat_t       mq[$];
  int          mptr;
  int          g;
  int          l;
  logic        rst_r;
  logic        hr_r;
  logic [2:0]  hold_v;
  logic [11:0] hold_d;
  logic [2:0]  er;
  logic [1:0]  el;
  logic [3:0]  ed;

  initial begin
    RESET               = 1'b1;
    handshake_arr_valid = 3'b111;
    handshake_arr_data  = 12'h321;
    handshake_ready     = 1'b1;

    applyStimulus(1'b1, 3'b111, 12'h321, 1'b1);
    applyStimulus(1'b1, 3'b111, 12'h321, 1'b1);
    checkVal("reset.lane", int'(handshake_lane), 0);

    tbl[0]  = mk(1, 3'b111, 12'h321, 1, 3'b000, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 3'b111, 12'h321, 1, 3'b001, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 3'b111, 12'h321, 1, 3'b010, 1, 1, 1, 0, 4'h1);
    tbl[3]  = mk(0, 3'b111, 12'h321, 1, 3'b100, 1, 1, 1, 1, 4'h2);
    tbl[4]  = mk(0, 3'b111, 12'h321, 1, 3'b001, 1, 1, 1, 2, 4'h3);
    tbl[5]  = mk(0, 3'b111, 12'h321, 1, 3'b010, 1, 1, 1, 0, 4'h1);
    tbl[6]  = mk(0, 3'b111, 12'h321, 1, 3'b100, 1, 1, 1, 1, 4'h2);
    tbl[7]  = mk(0, 3'b100, 12'hA21, 1, 3'b100, 1, 1, 1, 2, 4'h3);
    tbl[8]  = mk(0, 3'b000, 12'hA21, 1, 3'b000, 1, 1, 1, 2, 4'hA);
    tbl[9]  = mk(0, 3'b110, 12'h650, 1, 3'b010, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 3'b100, 12'h650, 1, 3'b100, 1, 1, 1, 1, 4'h5);
    tbl[11] = mk(0, 3'b000, 12'h650, 1, 3'b000, 1, 1, 1, 2, 4'h6);
    tbl[12] = mk(0, 3'b000, 12'h650, 1, 3'b000, 0, 0, 1, 0, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].hready);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp_ready, tbl[i].exp_count,
                  tbl[i].exp_hvalid, tbl[i].chk_valid, tbl[i].exp_lane, tbl[i].exp_data);
    end

    // Backpressure until full, pop while full, then reset with two beats buffered.
    applyStimulus(0, 3'b111, 12'h321, 0); checkOutput("bp1", 3'b001, 0, 0, 1, 0, 0);
    applyStimulus(0, 3'b111, 12'h321, 0); checkOutput("bp2", 3'b010, 1, 1, 1, 0, 4'h1);
    applyStimulus(0, 3'b111, 12'h321, 0); checkOutput("full", 3'b000, 2, 1, 1, 0, 4'h1);
    applyStimulus(0, 3'b111, 12'h321, 1); checkOutput("fullpop", 3'b000, 2, 1, 1, 0, 4'h1);
    applyStimulus(0, 3'b111, 12'h321, 1); checkOutput("pushpop", 3'b100, 1, 1, 1, 1, 4'h2);
    applyStimulus(0, 3'b111, 12'h321, 0); checkOutput("refill", 3'b001, 1, 1, 1, 2, 4'h3);
    applyStimulus(1, 3'b111, 12'h321, 1); checkOutput("rstfull", 3'b000, 2, 1, 0, 0, 0);
    applyStimulus(0, 3'b000, 12'h321, 1); checkOutput("postrst", 3'b000, 0, 0, 1, 0, 0);
    applyStimulus(0, 3'b000, 12'h321, 1); checkOutput("nostale", 3'b000, 0, 0, 1, 0, 0);

    // Random traffic; producers hold valid/data until their beat is taken.
    applyStimulus(1, 3'b000, 12'h000, 1);
    mq.delete();
    mptr   = 0;
    hold_v = '0;
    hold_d = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_r = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < N; i++) begin
        if (!hold_v[i] && ($urandom_range(0, 1) == 1)) begin
          hold_v[i]          = 1'b1;
          hold_d[i*4 +: 4]   = 4'($urandom);
        end
      end
      hr_r = ($urandom_range(0, 9) < 7);
      applyStimulus(rst_r, hold_v, hold_d, hr_r);

      g  = -1;
      er = '0;
      if (!rst_r && mq.size() < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          l = (mptr + k) % N;
          if (g < 0 && hold_v[l]) g = l;
        end
        if (g >= 0) er[g] = 1'b1;
      end
      el = '0;
      ed = '0;
      if (mq.size() != 0) begin
        el = 2'(mq[0].lane);
        ed = mq[0].data;
      end
      checkOutput("rand", er, 2'(mq.size()), mq.size() != 0, !rst_r, el, ed);

      if (rst_r) begin
        mq.delete();
        mptr = 0;
      end else begin
        if (mq.size() != 0 && hr_r) void'(mq.pop_front());
        if (g >= 0) begin
          mq.push_back('{g, hold_d[g*4 +: 4]});
          mptr      = (g + 1) % N;
          hold_v[g] = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
